// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 serial receiver with mid-bit sampling, framing check and
//                a one-entry valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] c_half_last = CW'(HALF - 1);
    localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rxd_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;
    logic          w_good_stop;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        w_good_stop = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == c_half_last) begin
                    // A high sample at mid-start means the low was a glitch.
                    if (!rxd_s_q) begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == c_bit_last) begin
                    shreg_d[bit_idx_q] = rxd_s_q;
                    cnt_d              = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        state_d     = S_IDLE;
                        w_good_stop = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rxd_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A consumer taking the old byte on the delivery edge frees the slot.
        if (w_good_stop) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shreg_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            rxd_s_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed, table-driven self-checking bench for uart_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB = 100;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    logic       prev_valid = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
    int         valid_rises = 0, ferr_cnt = 0, ovr_cnt = 0;
    int         ferr_wide = 0, ovr_wide = 0;
    int         rise_cyc = 0, ferr_cyc = 0, ovr_cyc = 0;
    logic [7:0] acc_q[$];

    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            valid_rises++;
            rise_cyc = cyc;
        end
        if (out_valid && out_ready) acc_q.push_back(out_data);
        if (frame_err) begin
            ferr_cnt++;
            ferr_cyc = cyc;
            if (prev_ferr) ferr_wide++;
        end
        if (overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
            if (prev_ovr) ovr_wide++;
        end
        prev_valid = out_valid;
        prev_ferr  = frame_err;
        prev_ovr   = overrun;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    int e0 = 0;

    // Call at a rising edge; each bit spans exactly CPB edges, E0 is the next edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        #1 rxd = 1'b0;
        e0 = cyc + 1;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rxd = stop_bit;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic pulse_ready();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_acc;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc0, f0, o0, r0, t;

        vecs[0] = '{8'h55, 1'b1, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 0, 1};
        vecs[5] = '{8'hA5, 1'b1, 1, 0};

        rst = 1'b1; rxd = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_data",  int'(out_data), 0);
        chk("reset_busy",  int'(busy), 0);
        chk("reset_ferr",  int'(frame_err), 0);
        chk("reset_ovr",   int'(overrun), 0);
        @(posedge clk);

        // ---- table-driven single frames, consumer always ready ----
        #1 out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            acc0 = acc_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            #1 rxd = 1'b1;
            repeat (20) @(posedge clk);
            @(negedge clk);
            chk("vec_accepted", acc_q.size() - acc0, vecs[i].exp_acc);
            chk("vec_ferr", ferr_cnt - f0, vecs[i].exp_ferr);
            chk("vec_ovr", ovr_cnt - o0, 0);
            chk("vec_busy_idle", int'(busy), 0);
            if (vecs[i].exp_acc == 1) begin
                if (acc_q.size() > acc0) chk("vec_data", int'(acc_q[acc0]), int'(vecs[i].data));
                chk("vec_latency", rise_cyc - e0, LAT);
            end else begin
                chk("vec_ferr_edge", ferr_cyc - e0, LAT);
            end
            @(posedge clk);
        end

        // ---- back-to-back frames, first held until consumer pulses ready ----
        #1 out_ready = 1'b0;
        @(posedge clk);
        acc0 = acc_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        fork
            begin
                send_frame(8'hA5, 1'b1);
                send_frame(8'h00, 1'b1);
            end
            begin
                t = 0;
                while (!out_valid && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                chk("b2b_first_valid_seen", int'(t < 3000), 1);
                pulse_ready();
            end
        join
        #1 rxd = 1'b1;
        @(negedge clk);
        chk("b2b_first_byte_count", acc_q.size() - acc0, 1);
        if (acc_q.size() > acc0) chk("b2b_first_byte", int'(acc_q[acc0]), 8'hA5);
        chk("b2b_second_valid", int'(out_valid), 1);
        chk("b2b_second_data", int'(out_data), 8'h00);
        pulse_ready();
        @(negedge clk);
        chk("b2b_total_count", acc_q.size() - acc0, 2);
        if (acc_q.size() > acc0 + 1) chk("b2b_second_byte", int'(acc_q[acc0 + 1]), 8'h00);
        chk("b2b_valid_cleared", int'(out_valid), 0);
        chk("b2b_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        @(posedge clk);

        // ---- glitch rejection ----
        r0 = valid_rises; f0 = ferr_cnt;
        #1 rxd = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy_high", int'(busy), 1);
        repeat (10) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_low", int'(busy), 0);
        chk("glitch_no_valid", valid_rises - r0, 0);
        chk("glitch_no_ferr", ferr_cnt - f0, 0);
        @(posedge clk);

        // ---- framing error followed by a break ----
        r0 = valid_rises; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (500) @(posedge clk);
        @(negedge clk);
        chk("break_ferr_once", ferr_cnt - f0, 1);
        chk("break_ferr_edge", ferr_cyc - e0, LAT);
        chk("break_busy_held", int'(busy), 1);
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("break_busy_released", int'(busy), 0);
        repeat (1100) @(posedge clk);
        @(negedge clk);
        chk("break_no_valid", valid_rises - r0, 0);
        chk("break_no_restart", ferr_cnt - f0, 1);
        @(posedge clk);

        // ---- overrun ----
        acc0 = acc_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        #1 rxd = 1'b1;
        @(negedge clk);
        chk("ovr_valid_held", int'(out_valid), 1);
        chk("ovr_data_kept", int'(out_data), 8'h12);
        chk("ovr_pulse_once", ovr_cnt - o0, 1);
        chk("ovr_pulse_edge", ovr_cyc - e0, LAT);
        chk("ovr_no_ferr", ferr_cnt - f0, 0);
        pulse_ready();
        @(negedge clk);
        chk("ovr_valid_cleared", int'(out_valid), 0);
        chk("ovr_accept_count", acc_q.size() - acc0, 1);
        if (acc_q.size() > acc0) chk("ovr_accept_byte", int'(acc_q[acc0]), 8'h12);
        @(posedge clk);

        // ---- reset mid-frame with a byte pending ----
        send_frame(8'h5A, 1'b1);
        #1 rxd = 1'b1;
        repeat (5) @(posedge clk);
        f0 = ferr_cnt; o0 = ovr_cnt; r0 = valid_rises;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                #2;
                while (cyc < e0 + 4 * CPB + 30) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("rst_valid", int'(out_valid), 0);
                chk("rst_data", int'(out_data), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_flags", int'(frame_err) + int'(overrun), 0);
            end
        join
        #1 rxd = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("rst_no_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        chk("rst_no_valid", valid_rises - r0, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        acc0 = acc_q.size();
        send_frame(8'h81, 1'b1);
        #1 rxd = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_rst_count", acc_q.size() - acc0, 1);
        if (acc_q.size() > acc0) chk("post_rst_byte", int'(acc_q[acc0]), 8'h81);

        chk("ferr_pulse_width", ferr_wide, 0);
        chk("ovr_pulse_width", ovr_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
